paula_disk_dmareq: RTL and testbench

//  Paula-side disk DMA requester: word FIFO between the floppy MFM word stream and the Agnus disk DMA slots.
//  - Decodes DSKLEN, counts words and raises dmal/dmas toward the Agnus disk DMA engine.
//  - Serves the resulting DSKDATR (disk->memory) and DSKDAT (memory->disk) bus cycles.
//  - Pulses the disk-block-done interrupt.

---
 rtl/paula_disk_dmareq.sv | 224 ++++++++++++++++++++++
 tb/tb_paula_disk_dmareq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paula_disk_dmareq.sv
// Paula disk DMA requester: small word FIFO between the MFM word stream and
// the Agnus disk DMA slots. DSKLEN must be written twice with DMAEN=1 to start
// a transfer. READ moves disk words to memory through DSKDATR cycles. WRITE
// moves memory words to the encoder through DSKDAT cycles.
//
// Optional feature macro: PAULA_DSKSYNC_EN. When it is defined, the inputs
// wordsync and sync_match are added, and READ capture can wait for a sync word.
//
// Ports:
//   clk, reset_n         bus clock, asynchronous active-low reset
//   clk7_en              clock enable; no state changes while low
//   reg_address_in[8:1]  register address of the current bus cycle
//   data_in              bus write data (DSKLEN, DSKDAT)
//   data_out             FIFO head during a DSKDATR cycle in READ, else 0
//   dmal, dmas           DMA request and direction (1 = memory->disk)
//   din, din_valid       decoded MFM word from the disk
//   dout, dout_valid     word toward the MFM encoder
//   dout_ready           encoder consumes dout
//   blckint              block-complete pulse
//   overrun              sticky; a disk word was dropped on a full FIFO
module paula_disk_dmareq #(
  parameter int unsigned FIFO_AW = 2,
  parameter logic [8:0]  DSKLEN  = 9'h024,
  parameter logic [8:0]  DSKDAT  = 9'h026,
  parameter logic [8:0]  DSKDATR = 9'h008
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic [8:1]  reg_address_in,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        dmal,
  output logic        dmas,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
`ifdef PAULA_DSKSYNC_EN
  input  logic        wordsync,
  input  logic        sync_match,
`endif
  output logic        blckint,
  output logic        overrun
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned CW    = 14;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic          overrun_q, overrun_d;
`ifdef PAULA_DSKSYNC_EN
  logic          sync_seen_q, sync_seen_d;
`endif

  logic        empty, full, dsklen_wr, dskdat_wr, ack_rd, pop_rd, capture_ok;
  logic        push, pop, flush;
  logic [15:0] head, wdata;

  // Bus and FIFO status decode from registered state
  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == LW'(DEPTH));
    head      = mem_q[rptr_q];
    dsklen_wr = (reg_address_in == DSKLEN[8:1]);
    dskdat_wr = (reg_address_in == DSKDAT[8:1]) && (state_q == S_WRITE);
    ack_rd    = (reg_address_in == DSKDATR[8:1]) && (state_q == S_READ);
    pop_rd    = ack_rd && !empty;
`ifdef PAULA_DSKSYNC_EN
    capture_ok = !wordsync || sync_seen_q;
`else
    capture_ok = 1'b1;
`endif
  end

  // Outputs decoded from registered state, level and count
  always_comb begin
    data_out   = pop_rd ? head : 16'h0000;
    dout_valid = (state_q == S_WRITE) && !empty;
    dout       = dout_valid ? head : 16'h0000;
    dmas       = (state_q == S_WRITE);
    dmal       = (count_q != '0) &&
                 (((state_q == S_READ) && !empty) || ((state_q == S_WRITE) && !full));
    blckint    = (state_q == S_DONE);
    overrun    = overrun_q;
  end

  // Next-state, counter and FIFO update
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    mem_d     = mem_q;
    overrun_d = overrun_q;
`ifdef PAULA_DSKSYNC_EN
    sync_seen_d = sync_seen_q;
`endif
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    wdata = din;

    if (clk7_en) begin
      case (state_q)
        S_IDLE: begin
          if (dsklen_wr && data_in[15]) begin
            state_d = S_ARMED;
            count_d = data_in[13:0];
          end
        end
        S_ARMED: begin
          if (dsklen_wr && data_in[15]) begin
            state_d = data_in[14] ? S_WRITE : S_READ;
            count_d = data_in[13:0];
`ifdef PAULA_DSKSYNC_EN
            sync_seen_d = 1'b0;
`endif
          end
        end
        S_READ: begin
`ifdef PAULA_DSKSYNC_EN
          if (sync_match) sync_seen_d = 1'b1;
`endif
          if (din_valid && capture_ok) begin
            if (full) overrun_d = 1'b1;
            else      push      = 1'b1;
          end
          if (pop_rd) begin
            pop = 1'b1;
            if (count_q != '0) count_d = count_q - CW'(1);
            // Last word acknowledged: whatever is still buffered is discarded
            if (count_q == CW'(1)) begin
              state_d = S_DONE;
              flush   = 1'b1;
            end
          end else if (count_q == '0) begin
            state_d = S_DONE;
            flush   = 1'b1;
          end
        end
        S_WRITE: begin
          wdata = data_in;
          if (dskdat_wr && !full) begin
            push = 1'b1;
            if (count_q != '0) count_d = count_q - CW'(1);
          end
          if (dout_valid && dout_ready) pop = 1'b1;
          // Finish only once the encoder has drained every word
          if ((count_q == '0) && empty) state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (dsklen_wr && !data_in[15]) begin
        state_d   = S_IDLE;
        flush     = 1'b1;
        overrun_d = 1'b0;
      end

      if (flush) begin
        wptr_d  = '0;
        rptr_d  = '0;
        level_d = '0;
      end else begin
        if (push) begin
          mem_d[wptr_q] = wdata;
          wptr_d        = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        level_d = level_q + LW'(push) - LW'(pop);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
`ifdef PAULA_DSKSYNC_EN
      sync_seen_q <= 1'b0;
`endif
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
`ifdef PAULA_DSKSYNC_EN
      sync_seen_q <= sync_seen_d;
`endif
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_paula_disk_dmareq.sv
module tb_paula_disk_dmareq;

  localparam logic [7:0] A_LEN  = 8'h12;
  localparam logic [7:0] A_DAT  = 8'h13;
  localparam logic [7:0] A_DATR = 8'h04;
  localparam logic [7:0] A_NONE = 8'hFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk7_en = 1'b1;
  logic [7:0]  reg_address_in = A_NONE;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        dmal, dmas;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        blckint, overrun;
`ifdef PAULA_DSKSYNC_EN
  logic        wordsync = 1'b0;
  logic        sync_match = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  paula_disk_dmareq dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en),
    .reg_address_in(reg_address_in), .data_in(data_in), .data_out(data_out),
    .dmal(dmal), .dmas(dmas), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
`ifdef PAULA_DSKSYNC_EN
    .wordsync(wordsync), .sync_match(sync_match),
`endif
    .blckint(blckint), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] w;
    logic        dv;
    logic        rdy;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [36:0] pk(input logic [15:0] dat_o, input logic [15:0] dou,
                                     input logic l, input logic s, input logic v,
                                     input logic b, input logic o);
    return {dat_o, dou, l, s, v, b, o};
  endfunction

  function automatic logic [36:0] outs();
    return {data_out, dout, dmal, dmas, dout_valid, blckint, overrun};
  endfunction

  task automatic addv(input logic [7:0] a, input logic [15:0] d, input logic [15:0] w,
                      input logic dv, input logic rdy, input logic [36:0] exp);
    vec_t v;
    v.addr = a; v.data = d; v.w = w; v.dv = dv; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [15:0] d, input logic [15:0] w,
                       input logic dv, input logic rdy);
    reg_address_in = a; data_in = d; din = w; din_valid = dv; dout_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    reg_address_in = A_NONE; data_in = '0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
  endtask

  task automatic bus(input logic [7:0] a, input logic [15:0] d);
    drive(a, d, 16'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic feed(input logic [15:0] w);
    drive(A_NONE, 16'h0, w, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    // Disk->memory block of four words
    addv(A_LEN,  16'h8004, 16'h0, 0, 0, pk(16'h0, 16'h0, 0, 0, 0, 0, 0));
    addv(A_NONE, 16'h0,    16'h0, 0, 0, pk(16'h0, 16'h0, 0, 0, 0, 0, 0));
    addv(A_LEN,  16'h8004, 16'h0, 0, 0, pk(16'h0, 16'h0, 0, 0, 0, 0, 0));
    addv(A_NONE, 16'h0, 16'hA11A, 1, 0, pk(16'h0, 16'h0, 0, 0, 0, 0, 0));
    addv(A_NONE, 16'h0, 16'hB22B, 1, 0, pk(16'h0, 16'h0, 1, 0, 0, 0, 0));
    addv(A_NONE, 16'h0, 16'hC33C, 1, 0, pk(16'h0, 16'h0, 1, 0, 0, 0, 0));
    addv(A_NONE, 16'h0, 16'hD44D, 1, 0, pk(16'h0, 16'h0, 1, 0, 0, 0, 0));
    addv(A_DATR, 16'h0, 16'h0, 0, 0, pk(16'hA11A, 16'h0, 1, 0, 0, 0, 0));
    addv(A_DATR, 16'h0, 16'h0, 0, 0, pk(16'hB22B, 16'h0, 1, 0, 0, 0, 0));
    addv(A_DATR, 16'h0, 16'h0, 0, 0, pk(16'hC33C, 16'h0, 1, 0, 0, 0, 0));
    addv(A_DATR, 16'h0, 16'h0, 0, 0, pk(16'hD44D, 16'h0, 1, 0, 0, 0, 0));
    addv(A_NONE, 16'h0, 16'h0, 0, 0, pk(16'h0, 16'h0, 0, 0, 0, 1, 0));
    addv(A_NONE, 16'h0, 16'h0, 0, 0, pk(16'h0, 16'h0, 0, 0, 0, 0, 0));
    // Memory->disk block of three words
    addv(A_LEN,  16'hC003, 16'h0, 0, 0, pk(16'h0, 16'h0, 0, 0, 0, 0, 0));
    addv(A_LEN,  16'hC003, 16'h0, 0, 0, pk(16'h0, 16'h0, 0, 0, 0, 0, 0));
    addv(A_DAT,  16'h0001, 16'h0, 0, 1, pk(16'h0, 16'h0, 1, 1, 0, 0, 0));
    addv(A_DAT,  16'h0002, 16'h0, 0, 1, pk(16'h0, 16'h1, 1, 1, 1, 0, 0));
    addv(A_DAT,  16'h0003, 16'h0, 0, 1, pk(16'h0, 16'h2, 1, 1, 1, 0, 0));
    addv(A_NONE, 16'h0, 16'h0, 0, 0, pk(16'h0, 16'h3, 0, 1, 1, 0, 0));
    addv(A_NONE, 16'h0, 16'h0, 0, 1, pk(16'h0, 16'h3, 0, 1, 1, 0, 0));
    addv(A_NONE, 16'h0, 16'h0, 0, 0, pk(16'h0, 16'h0, 0, 1, 0, 0, 0));
    addv(A_NONE, 16'h0, 16'h0, 0, 0, pk(16'h0, 16'h0, 0, 0, 0, 1, 0));
    addv(A_NONE, 16'h0, 16'h0, 0, 0, pk(16'h0, 16'h0, 0, 0, 0, 0, 0));

    // Reset state
    #2;
    chk("reset_outputs", outs(), '0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of a READ with three words buffered
    bus(A_LEN, 16'h8010);
    bus(A_LEN, 16'h8010);
    feed(16'h0111); feed(16'h0222); feed(16'h0333);
    #1;
    chk("pre_reset_dmal", 37'(dmal), 37'(1));
    reset_n = 1'b0;
    #1;
    chk("midread_reset_outs", outs(), '0);
    reset_n = 1'b1;
    tick();
    bus(A_LEN, 16'h8004);
    feed(16'h0444); feed(16'h0555);
    drive(A_DATR, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("after_reset_single_write", outs(), '0);
    tick();
    bus(A_LEN, 16'h0000);

    // Table vectors
    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].data, vecs[i].w, vecs[i].dv, vecs[i].rdy);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      tick();
    end

    // Overrun: one word more than the FIFO holds
    bus(A_LEN, 16'h8008);
    bus(A_LEN, 16'h8008);
    for (int i = 0; i < 5; i++) feed(16'h1000 + 16'(i));
    #1;
    chk("ovr_dmal", 37'(dmal), 37'(1));
    chk("ovr_flag", 37'(overrun), 37'(1));
    for (int i = 0; i < 4; i++) begin
      drive(A_DATR, 16'h0, 16'h0, 1'b0, 1'b0);
      chk($sformatf("ovr_word%0d", i), 37'(data_out), 37'(16'h1000 + 16'(i)));
      tick();
    end
    #1;
    chk("ovr_extra_lost", {35'(0), dmal, overrun}, 37'(1));
    bus(A_LEN, 16'h0000);
    #1;
    chk("ovr_cleared", outs(), '0);

    // Same-cycle push and pop at level 1
    bus(A_LEN, 16'h8003);
    bus(A_LEN, 16'h8003);
    feed(16'h5A5A);
    drive(A_DATR, 16'h0, 16'h6B6B, 1'b1, 1'b0);
    chk("simul_head", {20'(0), data_out, dmal}, {20'(0), 16'h5A5A, 1'b1});
    tick();
    drive(A_DATR, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("simul_level_kept", 37'(data_out), 37'(16'h6B6B));
    tick();
    #1;
    chk("simul_empty", 37'(dmal), 37'(0));
    feed(16'h7C7C);
    drive(A_DATR, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("simul_last", 37'(data_out), 37'(16'h7C7C));
    tick();
    #1;
    chk("simul_count_done", 37'(blckint), 37'(1));
    tick();

    // Forced ack on an empty FIFO
    bus(A_LEN, 16'h8002);
    bus(A_LEN, 16'h8002);
    drive(A_DATR, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("underflow", {20'(0), data_out, dmal}, '0);
    tick();
    bus(A_LEN, 16'h0000);

    // Zero count written twice
    bus(A_LEN, 16'h8000);
    bus(A_LEN, 16'h8000);
    #1;
    chk("zero_cnt_first", {35'(0), dmal, blckint}, '0);
    tick();
    #1;
    chk("zero_cnt_done", {35'(0), dmal, blckint}, 37'(1));
    tick();
    #1;
    chk("zero_cnt_idle", outs(), '0);

    // Clock enable low: DSKLEN writes must not take effect
    clk7_en = 1'b0;
    bus(A_LEN, 16'h8004);
    bus(A_LEN, 16'h8004);
    clk7_en = 1'b1;
    feed(16'h1234); feed(16'h5678);
    #1;
    chk("clk7_en_gate", outs(), '0);

`ifdef PAULA_DSKSYNC_EN
    // Words before the sync mark are discarded
    wordsync = 1'b1;
    bus(A_LEN, 16'h8002);
    bus(A_LEN, 16'h8002);
    feed(16'hDEAD);
    sync_match = 1'b1;
    feed(16'h4489);
    sync_match = 1'b0;
    feed(16'hCAFE);
    feed(16'hF00D);
    drive(A_DATR, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("sync_first", 37'(data_out), 37'(16'hCAFE));
    tick();
    drive(A_DATR, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("sync_second", 37'(data_out), 37'(16'hF00D));
    tick();
    #1;
    chk("sync_done", 37'(blckint), 37'(1));
    tick();
    wordsync = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
